fpu_addsub_sched: RTL and testbench

- Round-robin scheduler that shares one single-precision add/sub datapath (add_sub_main) between NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and drives the datapath's a/b/operation_select from registered issue outputs.
- Tracks in-flight operations with a tag pipeline matched to the datapath latency, and returns each result with the id of the requester that issued it.
- Sits between the FPU front-end request ports and the shared add/sub instance.

---
 rtl/fpu_addsub_sched.sv | 164 ++++++++++++++++
 tb/tb_fpu_addsub_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpu_addsub_sched
// Purpose  : Round-robin issue of NUM_REQ requesters onto one shared
//            single-precision add/sub datapath, with id-tagged responses.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_addsub_sched #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int ID_BITS   = 2,
  parameter int LATENCY   = 1,
  parameter int PIPELINED = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]         fpu_a,
  output logic [WIDTH-1:0]         fpu_b,
  output logic                     fpu_op,
  input  logic [WIDTH-1:0]         fpu_result,
  output logic                     rsp_valid,
  output logic [ID_BITS-1:0]       rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy
);

  logic [ID_BITS-1:0]   r_ptr;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_BITS:0]     w_sum;
  logic [ID_BITS-1:0]   w_win;
  logic                 w_found;
  logic                 w_issue_ok;
  logic                 w_xfer;
  logic                 w_fsm_idle;
  logic                 w_fsm_busy;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic                 w_op;
  logic [LATENCY:0]     r_tag_vld;
  logic [ID_BITS-1:0]   r_tag_id [LATENCY+1];

  // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_dbl   = {req_valid, req_valid};
    w_rot   = NUM_REQ'(w_dbl >> r_ptr);
    w_found = 1'b0;
    w_sum   = '0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (ID_BITS+1)'(k);
        if (w_sum >= (ID_BITS+1)'(NUM_REQ)) begin
          w_sum = w_sum - (ID_BITS+1)'(NUM_REQ);
        end
        w_win = w_sum[ID_BITS-1:0];
      end
    end
  end

  assign w_issue_ok = reset && w_fsm_idle;
  assign w_xfer     = w_issue_ok && w_found;

  always_comb begin
    req_ready = '0;
    w_a       = '0;
    w_b       = '0;
    w_op      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_BITS'(i)) begin
        req_ready[i] = w_xfer;
        w_a          = req_a[i*WIDTH +: WIDTH];
        w_b          = req_b[i*WIDTH +: WIDTH];
        w_op         = req_op[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr  <= '0;
      fpu_a  <= '0;
      fpu_b  <= '0;
      fpu_op <= 1'b0;
    end else if (w_xfer) begin
      r_ptr  <= (w_win == ID_BITS'(NUM_REQ-1)) ? '0 : w_win + ID_BITS'(1);
      fpu_a  <= w_a;
      fpu_b  <= w_b;
      fpu_op <= w_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tag_vld <= '0;
      for (int s = 0; s <= LATENCY; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[LATENCY-1:0], w_xfer};
      r_tag_id[0] <= w_win;
      for (int s = 1; s <= LATENCY; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      assign w_fsm_idle = 1'b1;
      assign w_fsm_busy = 1'b0;
    end else begin : g_serial
      localparam int         CNT_W   = $clog2(LATENCY + 1);
      localparam logic [1:0] ST_IDLE = 2'd0;
      localparam logic [1:0] ST_EXEC = 2'd1;
      localparam logic [1:0] ST_RESP = 2'd2;

      logic [1:0]       r_state;
      logic [CNT_W-1:0] r_cnt;

      // Leaving EXEC on the last count lands RESP in the same cycle the tag
      // pipeline presents the result.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_xfer) begin
                r_state <= ST_EXEC;
                r_cnt   <= CNT_W'(LATENCY);
              end
            end
            ST_EXEC: begin
              r_cnt <= r_cnt - 1'b1;
              if (r_cnt <= CNT_W'(1)) begin
                r_state <= ST_RESP;
              end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
          endcase
        end
      end

      assign w_fsm_idle = (r_state == ST_IDLE);
      assign w_fsm_busy = (r_state != ST_IDLE);
    end
  endgenerate

  assign rsp_valid  = r_tag_vld[LATENCY];
  assign rsp_id     = rsp_valid ? r_tag_id[LATENCY] : '0;
  assign rsp_result = rsp_valid ? fpu_result : '0;
  assign busy       = (|r_tag_vld) || w_fsm_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_addsub_sched
// Purpose  : Self-checking bench for fpu_addsub_sched (pipelined and serial).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_sched;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDB = 2;

  typedef struct {
    int               due;
    logic [IDB-1:0]   id;
    logic [W-1:0]     res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [N-1:0]   p_valid, p_ready, p_op;
  logic [N*W-1:0] p_a, p_b;
  logic [W-1:0]   p_fa, p_fb, p_res;
  logic [W-1:0]   p_fres = '0;
  logic           p_fop, p_rv, p_busy;
  logic [IDB-1:0] p_rid;

  logic [N-1:0]   s_valid, s_ready, s_op;
  logic [N*W-1:0] s_a, s_b;
  logic [W-1:0]   s_fa, s_fb, s_res;
  logic [W-1:0]   s_fres = '0;
  logic           s_fop, s_rv, s_busy;
  logic [IDB-1:0] s_rid;

  int n_cmp  = 0;
  int n_fail = 0;

  fpu_addsub_sched #(.WIDTH(W), .NUM_REQ(N), .ID_BITS(IDB), .LATENCY(1), .PIPELINED(1)) dut_p (
    .clk(clk), .reset(reset), .req_valid(p_valid), .req_ready(p_ready),
    .req_a(p_a), .req_b(p_b), .req_op(p_op), .fpu_a(p_fa), .fpu_b(p_fb),
    .fpu_op(p_fop), .fpu_result(p_fres), .rsp_valid(p_rv), .rsp_id(p_rid),
    .rsp_result(p_res), .busy(p_busy));

  fpu_addsub_sched #(.WIDTH(W), .NUM_REQ(N), .ID_BITS(IDB), .LATENCY(1), .PIPELINED(0)) dut_s (
    .clk(clk), .reset(reset), .req_valid(s_valid), .req_ready(s_ready),
    .req_a(s_a), .req_b(s_b), .req_op(s_op), .fpu_a(s_fa), .fpu_b(s_fb),
    .fpu_op(s_fop), .fpu_result(s_fres), .rsp_valid(s_rv), .rsp_id(s_rid),
    .rsp_result(s_res), .busy(s_busy));

  // Single-precision values widened to double for arithmetic (normal numbers only).
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    if (x[30:0] == 31'd0) return {x[31], 63'd0};
    return {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(op ? ra - rb : ra + rb));
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Shared datapath stand-ins: one registered stage, as add_sub_main.
  always @(posedge clk) begin
    p_fres <= fp_calc(p_fa, p_fb, p_fop);
    s_fres <= fp_calc(s_fa, s_fb, s_fop);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; p_valid = '0; s_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; p_valid = '1; s_valid = '1; p_op = '0; s_op = '0;
    for (int i = 0; i < N; i++) begin
      p_a[i*W +: W] = rnd_fp(); p_b[i*W +: W] = rnd_fp();
      s_a[i*W +: W] = rnd_fp(); s_b[i*W +: W] = rnd_fp();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (p_ready !== '0) begin n_fail++; $display("FAIL reset_p_ready: got %b exp 0", p_ready); end
      n_cmp++; if (p_rv !== 1'b0) begin n_fail++; $display("FAIL reset_p_rsp_valid: got %b exp 0", p_rv); end
      n_cmp++; if (p_busy !== 1'b0) begin n_fail++; $display("FAIL reset_p_busy: got %b exp 0", p_busy); end
      n_cmp++; if (p_fa !== '0) begin n_fail++; $display("FAIL reset_p_fpu_a: got %h exp 0", p_fa); end
      n_cmp++; if (p_rid !== '0 || p_res !== '0) begin n_fail++; $display("FAIL reset_p_rsp: got id %0d res %h exp 0/0", p_rid, p_res); end
      n_cmp++; if (s_ready !== '0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_s: got ready %b busy %b exp 0/0", s_ready, s_busy); end
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (p_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant_p: got %b exp 0001", p_ready); end
    n_cmp++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant_s: got %b exp 0001", s_ready); end
    p_valid = '0; s_valid = '0;
  endtask

  task automatic test_single();
    @(negedge clk);
    p_valid = 4'b0010; p_op = '0;
    p_a[1*W +: W] = 32'h3F800000; p_b[1*W +: W] = 32'h40000000;
    #1;
    n_cmp++; if (p_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b exp 0010", p_ready); end
    @(negedge clk);
    p_valid = '0;
    n_cmp++; if (p_fa !== 32'h3F800000 || p_fb !== 32'h40000000 || p_fop !== 1'b0) begin
      n_fail++; $display("FAIL single_issue: got a %h b %h op %b exp 3f800000 40000000 0", p_fa, p_fb, p_fop); end
    n_cmp++; if (p_rv !== 1'b0 || p_busy !== 1'b1) begin n_fail++; $display("FAIL single_t1: got rv %b busy %b exp 0/1", p_rv, p_busy); end
    @(negedge clk);
    n_cmp++; if (p_rv !== 1'b1 || p_rid !== 2'd1 || p_res !== 32'h40400000) begin
      n_fail++; $display("FAIL single_rsp: got rv %b id %0d res %h exp 1 1 40400000", p_rv, p_rid, p_res); end
    @(negedge clk);
    n_cmp++; if (p_rv !== 1'b0 || p_res !== '0) begin n_fail++; $display("FAIL single_after: got rv %b res %h exp 0 0", p_rv, p_res); end
  endtask

  task automatic test_serial();
    do_reset();
    @(negedge clk);
    s_valid = 4'b0101; s_op = 4'b0001;
    s_a[0*W +: W] = 32'h40400000; s_b[0*W +: W] = 32'h3F800000;
    s_a[2*W +: W] = 32'h40800000; s_b[2*W +: W] = 32'h40800000;
    #1;
    n_cmp++; if (s_ready !== 4'b0001) begin n_fail++; $display("FAIL serial_grant0: got %b exp 0001", s_ready); end
    @(negedge clk);
    s_valid = 4'b0100; #1;
    n_cmp++; if (s_ready !== '0 || s_busy !== 1'b1) begin n_fail++; $display("FAIL serial_exec: got ready %b busy %b exp 0/1", s_ready, s_busy); end
    n_cmp++; if (s_fa !== 32'h40400000 || s_fop !== 1'b1) begin n_fail++; $display("FAIL serial_issue: got a %h op %b exp 40400000 1", s_fa, s_fop); end
    @(negedge clk);
    #1;
    n_cmp++; if (s_ready !== '0) begin n_fail++; $display("FAIL serial_resp_ready: got %b exp 0", s_ready); end
    n_cmp++; if (s_rv !== 1'b1 || s_rid !== 2'd0 || s_res !== 32'h40000000) begin
      n_fail++; $display("FAIL serial_rsp0: got rv %b id %0d res %h exp 1 0 40000000", s_rv, s_rid, s_res); end
    @(negedge clk);
    #1;
    n_cmp++; if (s_ready !== 4'b0100 || s_rv !== 1'b0) begin n_fail++; $display("FAIL serial_grant2: got ready %b rv %b exp 0100 0", s_ready, s_rv); end
    @(negedge clk);
    s_valid = '0; #1;
    n_cmp++; if (s_ready !== '0) begin n_fail++; $display("FAIL serial_exec2: got %b exp 0", s_ready); end
    @(negedge clk);
    n_cmp++; if (s_rv !== 1'b1 || s_rid !== 2'd2 || s_res !== 32'h41000000) begin
      n_fail++; $display("FAIL serial_rsp2: got rv %b id %0d res %h exp 1 2 41000000", s_rv, s_rid, s_res); end
    @(negedge clk);
    n_cmp++; if (s_busy !== 1'b0 || s_rv !== 1'b0) begin n_fail++; $display("FAIL serial_idle: got busy %b rv %b exp 0 0", s_busy, s_rv); end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  ea [N];
    logic [31:0]  eb [N];
    logic [31:0]  er [N];
    logic [N-1:0] erdy;
    ea = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h41200000};
    eb = '{32'h40000000, 32'h40000000, 32'h3FC00000, 32'h40800000};
    er = '{32'h40400000, 32'h40800000, 32'h40600000, 32'h40C00000};
    do_reset();
    p_op = 4'b1100;
    for (int i = 0; i < N; i++) begin
      p_a[i*W +: W] = ea[i]; p_b[i*W +: W] = eb[i];
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      p_valid = (c < 8) ? '1 : '0;
      #1;
      erdy = '0;
      if (c < 8) erdy[c % N] = 1'b1;
      n_cmp++; if (p_ready !== erdy) begin n_fail++; $display("FAIL b2b_grant c%0d: got %b exp %b", c, p_ready, erdy); end
      if (c >= 2 && c < 10) begin
        n_cmp++; if (p_rv !== 1'b1 || p_rid !== IDB'((c-2) % N) || p_res !== er[(c-2) % N]) begin
          n_fail++; $display("FAIL b2b_rsp c%0d: got rv %b id %0d res %h exp 1 %0d %h", c, p_rv, p_rid, p_res, (c-2) % N, er[(c-2) % N]); end
      end else begin
        n_cmp++; if (p_rv !== 1'b0) begin n_fail++; $display("FAIL b2b_norsp c%0d: got rv %b exp 0", c, p_rv); end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] erdy;
    logic [31:0]  ta [N];
    logic [31:0]  tb [N];
    logic         to [N];
    exp_t         q [$];
    int           ptr, g;
    do_reset();
    ptr = 0; pend = '0;
    for (int c = 0; c < 320; c++) begin
      @(negedge clk);
      n_cmp++; if (p_busy !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b exp %b", c, p_busy, q.size() > 0); end
      if (q.size() > 0 && q[0].due == c) begin
        n_cmp++; if (p_rv !== 1'b1 || p_rid !== q[0].id || p_res !== q[0].res) begin
          n_fail++; $display("FAIL rand_rsp c%0d: got rv %b id %0d res %h exp 1 %0d %h", c, p_rv, p_rid, p_res, q[0].id, q[0].res); end
        void'(q.pop_front());
      end else begin
        n_cmp++; if (p_rv !== 1'b0) begin n_fail++; $display("FAIL rand_norsp c%0d: got rv %b exp 0", c, p_rv); end
      end
      for (int i = 0; i < N; i++) begin
        if (c < 300 && !pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1; ta[i] = rnd_fp(); tb[i] = rnd_fp(); to[i] = 1'($urandom);
          p_a[i*W +: W] = ta[i]; p_b[i*W +: W] = tb[i]; p_op[i] = to[i];
        end
      end
      p_valid = pend;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
      end
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      n_cmp++; if (p_ready !== erdy) begin n_fail++; $display("FAIL rand_grant c%0d: got %b exp %b", c, p_ready, erdy); end
      if (g >= 0) begin
        q.push_back('{c + 2, IDB'(g), fp_calc(ta[g], tb[g], to[g])});
        pend[g] = 1'b0;
        ptr = (g + 1) % N;
      end
    end
    p_valid = '0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] pend;
    logic [N-1:0] erdy;
    int           ptr, g, streak;
    do_reset();
    ptr = 0; pend = '0; streak = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      pend[2] = 1'b1;
      if (!pend[0] && (c % 2 == 0)) pend[0] = 1'b1;
      p_valid = pend;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
      end
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      n_cmp++; if (p_ready !== erdy) begin n_fail++; $display("FAIL fair_grant c%0d: got %b exp %b", c, p_ready, erdy); end
      if (p_ready[2]) streak = 0;
      else if (p_ready != '0) streak++;
      n_cmp++; if (streak > N - 1) begin n_fail++; $display("FAIL fair_starve c%0d: got streak %0d exp <= %0d", c, streak, N - 1); end
      if (g >= 0) begin
        pend[g] = 1'b0;
        ptr = (g + 1) % N;
      end
    end
    p_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_midflight_reset();
    do_reset();
    @(negedge clk);
    p_valid = 4'b1000; s_valid = 4'b1000;
    p_a[3*W +: W] = rnd_fp(); p_b[3*W +: W] = rnd_fp();
    s_a[3*W +: W] = rnd_fp(); s_b[3*W +: W] = rnd_fp();
    #1;
    n_cmp++; if (p_ready !== 4'b1000 || s_ready !== 4'b1000) begin
      n_fail++; $display("FAIL mid_grant: got p %b s %b exp 1000 1000", p_ready, s_ready); end
    @(negedge clk);
    p_valid = '0; s_valid = '0;
    n_cmp++; if (p_busy !== 1'b1 || s_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got p %b s %b exp 1 1", p_busy, s_busy); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_cmp++; if (p_busy !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_cleared: got p %b s %b exp 0 0", p_busy, s_busy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (p_rv !== 1'b0 || s_rv !== 1'b0) begin n_fail++; $display("FAIL mid_no_rsp c%0d: got p %b s %b exp 0 0", c, p_rv, s_rv); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_serial();
    test_back_to_back();
    test_random();
    test_fairness();
    test_midflight_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
